// File: rtl/fu_mult_pipe.sv
// Pipelined multiplier functional unit: STAGES-deep radix-2^(XLEN/STAGES) product with bubble-collapsing stall.
// Optional build macro FU_MULT_SQUASH_EN makes squash flush every in-flight entry.
module fu_mult_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int PRS_W  = 6,
    parameter int ROB_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       issue_op,
    input  logic [XLEN-1:0]  issue_a,
    input  logic [XLEN-1:0]  issue_b,
    input  logic [PRS_W-1:0] issue_prs,
    input  logic [ROB_W-1:0] issue_rob,
    input  logic             squash,
    input  logic             bs_hazard,
    output logic             rsb_fu_ready,
    output logic             fum_complete_req,
    output logic [XLEN-1:0]  out_value,
    output logic [PRS_W-1:0] out_prs,
    output logic [ROB_W-1:0] out_rob
);
    localparam int CW   = XLEN / STAGES;
    localparam int PW   = 2 * XLEN;
    localparam int LAST = STAGES - 1;

    typedef enum logic [1:0] {
        OP_MULT   = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    logic [STAGES-1:0] valid_reg;
    mul_op_e           op_reg  [STAGES];
    logic [PRS_W-1:0]  prs_reg [STAGES];
    logic [ROB_W-1:0]  rob_reg [STAGES];
    logic [PW-1:0]     a_reg   [STAGES];
    logic [XLEN-1:0]   b_reg   [STAGES];
    logic [PW-1:0]     acc_reg [STAGES];

    // Per-stage inputs: stage 0 is fed by the issue port, stage i by stage i-1.
    logic [STAGES-1:0] s_valid;
    mul_op_e           s_op    [STAGES];
    logic [PRS_W-1:0]  s_prs   [STAGES];
    logic [ROB_W-1:0]  s_rob   [STAGES];
    logic [PW-1:0]     s_a     [STAGES];
    logic [XLEN-1:0]   s_b     [STAGES];
    logic [PW-1:0]     s_acc   [STAGES];
    logic [PW-1:0]     acc_next[STAGES];

    logic [STAGES:0]   take;
    mul_op_e           issue_op_e;
    logic [PW-1:0]     issue_a_ext;

    assign issue_op_e  = mul_op_e'(issue_op);
    assign issue_a_ext = (issue_op_e == OP_MULHU) ? {{XLEN{1'b0}}, issue_a}
                                                  : {{XLEN{issue_a[XLEN-1]}}, issue_a};

    // take[i]: stage i may load this edge (it is empty or everything ahead of it moves).
    always_comb begin
        take         = '0;
        take[STAGES] = !bs_hazard;
        for (int i = STAGES - 1; i >= 0; i--) begin
            take[i] = !valid_reg[i] || take[i+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [CW-1:0] chunk;
            logic          neg;
            logic [PW-1:0] pp;

            if (gi == 0) begin : g_first
                assign s_valid[gi] = issue_valid;
                assign s_op[gi]    = issue_op_e;
                assign s_prs[gi]   = issue_prs;
                assign s_rob[gi]   = issue_rob;
                assign s_a[gi]     = issue_a_ext;
                assign s_b[gi]     = issue_b;
                assign s_acc[gi]   = '0;
            end else begin : g_rest
                assign s_valid[gi] = valid_reg[gi-1];
                assign s_op[gi]    = op_reg[gi-1];
                assign s_prs[gi]   = prs_reg[gi-1];
                assign s_rob[gi]   = rob_reg[gi-1];
                assign s_a[gi]     = a_reg[gi-1];
                assign s_b[gi]     = b_reg[gi-1];
                assign s_acc[gi]   = acc_reg[gi-1];
            end

            // A signed B contributes its top bit with negative weight, folded into the last chunk.
            assign chunk = s_b[gi][gi*CW +: CW];
            assign neg   = (gi == LAST) && chunk[CW-1] &&
                           (s_op[gi] == OP_MULT || s_op[gi] == OP_MULH);
            assign pp    = s_a[gi] * {{(PW-CW){neg}}, chunk};
            assign acc_next[gi] = s_acc[gi] + (pp << (gi * CW));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_reg[i]  <= OP_MULT;
                prs_reg[i] <= '0;
                rob_reg[i] <= '0;
                a_reg[i]   <= '0;
                b_reg[i]   <= '0;
                acc_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (take[i]) begin
                    valid_reg[i] <= s_valid[i];
                    op_reg[i]    <= s_op[i];
                    prs_reg[i]   <= s_prs[i];
                    rob_reg[i]   <= s_rob[i];
                    a_reg[i]     <= s_a[i];
                    b_reg[i]     <= s_b[i];
                    acc_reg[i]   <= acc_next[i];
                end
            end
`ifdef FU_MULT_SQUASH_EN
            if (squash) begin
                valid_reg <= '0;
            end
`endif
        end
    end

`ifndef FU_MULT_SQUASH_EN
    logic squash_unused;
    assign squash_unused = squash;
`endif

    assign fum_complete_req = valid_reg[LAST];
    assign rsb_fu_ready     = !rst && take[0];

    always_comb begin
        out_value = '0;
        out_prs   = '0;
        out_rob   = '0;
        if (valid_reg[LAST]) begin
            out_value = (op_reg[LAST] == OP_MULT) ? acc_reg[LAST][XLEN-1:0]
                                                  : acc_reg[LAST][PW-1:XLEN];
            out_prs   = prs_reg[LAST];
            out_rob   = rob_reg[LAST];
        end
    end
endmodule

// File: tb/tb_fu_mult_pipe.sv
// Self-checking bench for fu_mult_pipe: directed vector table, multi-cycle sequences, randomized scoreboard run.
module tb_fu_mult_pipe;
    localparam int XLEN   = 32;
    localparam int STAGES = 4;
    localparam int PRS_W  = 6;
    localparam int ROB_W  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic [1:0]       issue_op = 2'd0;
    logic [XLEN-1:0]  issue_a = '0;
    logic [XLEN-1:0]  issue_b = '0;
    logic [PRS_W-1:0] issue_prs = '0;
    logic [ROB_W-1:0] issue_rob = '0;
    logic             squash = 1'b0;
    logic             bs_hazard = 1'b0;
    logic             rsb_fu_ready;
    logic             fum_complete_req;
    logic [XLEN-1:0]  out_value;
    logic [PRS_W-1:0] out_prs;
    logic [ROB_W-1:0] out_rob;

    always #5 clk = ~clk;

    fu_mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .PRS_W(PRS_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_a(issue_a), .issue_b(issue_b), .issue_prs(issue_prs), .issue_rob(issue_rob),
        .squash(squash), .bs_hazard(bs_hazard), .rsb_fu_ready(rsb_fu_ready),
        .fum_complete_req(fum_complete_req), .out_value(out_value),
        .out_prs(out_prs), .out_rob(out_rob)
    );

    typedef struct {
        logic [XLEN-1:0]  val;
        logic [PRS_W-1:0] prs;
        logic [ROB_W-1:0] rob;
    } exp_t;

    typedef struct {
        logic [1:0]       op;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [PRS_W-1:0] prs;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  exp;
    } vec_t;

    exp_t            q[$];
    int              retire_cyc[$];
    logic [XLEN-1:0] retire_val[$];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;
    vec_t            tbl[10];

    // Reference: extend both operands to 2*XLEN, multiply, pick the half.
    function automatic logic [XLEN-1:0] model(logic [1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ax, bx, p;
        ax = (op == 2'd3) ? {{XLEN{1'b0}}, a} : {{XLEN{a[XLEN-1]}}, a};
        bx = (op <= 2'd1) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ax * bx;
        return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample and score at negedge, then return 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("ready", {63'd0, rsb_fu_ready}, {63'd0, !(q.size() == STAGES && bs_hazard)});
            if (fum_complete_req) begin
                if (q.size() == 0) begin
                    chk("spurious_complete", {63'd0, fum_complete_req}, 64'd0);
                end else begin
                    chk("out_value", {32'd0, out_value}, {32'd0, q[0].val});
                    chk("out_prs", {58'd0, out_prs}, {58'd0, q[0].prs});
                    chk("out_rob", {59'd0, out_rob}, {59'd0, q[0].rob});
                    if (!bs_hazard) begin
                        $display("retire cyc=%0d value=%h prs=%0d rob=%0d", cyc, out_value, out_prs, out_rob);
                        retire_cyc.push_back(cyc);
                        retire_val.push_back(out_value);
                        void'(q.pop_front());
                    end
                end
            end else begin
                chk("idle_zero", {21'd0, out_value, out_prs, out_rob}, 64'd0);
            end
            if (issue_valid && rsb_fu_ready)
                q.push_back('{model(issue_op, issue_a, issue_b), issue_prs, issue_rob});
`ifdef FU_MULT_SQUASH_EN
            if (squash) q.delete();
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [PRS_W-1:0] prs, input logic [ROB_W-1:0] rob);
        issue_valid = v;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_prs   = prs;
        issue_rob   = rob;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && q.size() != 0; k++) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int start;
        int n_exp;

        tbl[0] = '{2'd0, 32'd7,         32'd5,         6'd1,  5'd2,  32'h0000_0023};
        tbl[1] = '{2'd1, 32'hFFFF_FFFE, 32'd3,         6'd3,  5'd4,  32'hFFFF_FFFF};
        tbl[2] = '{2'd3, 32'hFFFF_0000, 32'h0000_FFFF, 6'd5,  5'd6,  32'h0000_FFFE};
        tbl[3] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_FFFF, 6'd7,  5'd8,  32'hFFFF_FFFF};
        tbl[4] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd9,  5'd10, 32'h0000_0001};
        tbl[5] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 6'd11, 5'd12, 32'h4000_0000};
        tbl[6] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13, 5'd14, 32'hFFFF_FFFE};
        tbl[7] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 5'd16, 32'h8000_0000};
        tbl[8] = '{2'd1, 32'd3,         32'hFFFF_FFFE, 6'd63, 5'd31, 32'hFFFF_FFFF};
        tbl[9] = '{2'd0, 32'h1234_5678, 32'h0000_0000, 6'd0,  5'd0,  32'h0000_0000};

        // Reset state
        #2;
        chk("rst_complete", {63'd0, fum_complete_req}, 64'd0);
        chk("rst_ready", {63'd0, rsb_fu_ready}, 64'd0);
        chk("rst_out", {21'd0, out_value, out_prs, out_rob}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Directed vector table: value, tags and latency
        for (int t = 0; t < 10; t++) begin
            drive(1'b1, tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].prs, tbl[t].rob);
            cycle();
            start = cyc;
            drive(1'b0, 2'd0, '0, '0, '0, '0);
            retire_cyc.delete();
            retire_val.delete();
            for (int k = 0; k < 20 && retire_cyc.size() == 0; k++) cycle();
            if (retire_cyc.size() == 0) begin
                chk("tbl_timeout", 64'd0, 64'd1);
            end else begin
                chk("tbl_latency", 64'(retire_cyc[0] - start), 64'(STAGES));
                chk("tbl_value", {32'd0, retire_val[0]}, {32'd0, tbl[t].exp});
            end
        end

        // Back-to-back issue: consecutive completions in order
        retire_cyc.delete();
        retire_val.delete();
        start = cyc + 1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'd0, 32'(i), 32'(i), 6'(i), 5'(i));
            cycle();
        end
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        drain(20);
        chk("b2b_count", 64'(retire_cyc.size()), 64'd4);
        for (int i = 0; i < 4 && i < retire_cyc.size(); i++) begin
            chk("b2b_cycle", 64'(retire_cyc[i]), 64'(start + STAGES + i));
            chk("b2b_value", {32'd0, retire_val[i]}, 64'((i + 1) * (i + 1)));
        end

        // bs_hazard held 6 cycles under continuous issue
        retire_cyc.delete();
        bs_hazard = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'(i % 4), $urandom, $urandom, 6'(20 + i), 5'(i));
            cycle();
        end
        chk("hazard_full_ready", {63'd0, rsb_fu_ready}, 64'd0);
        bs_hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 32'(i + 10), 32'd3, 6'(40 + i), 5'(i));
            cycle();
        end
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        drain(30);
        chk("hazard_no_loss", 64'(retire_cyc.size()), 64'd7);

        // Squash with 3 in flight plus a same-cycle issue, then 6*7
        retire_cyc.delete();
        retire_val.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 32'(i + 1), 32'd2, 6'(50 + i), 5'(i));
            cycle();
        end
        squash = 1'b1;
        drive(1'b1, 2'd0, 32'd5, 32'd5, 6'd55, 5'd5);
        cycle();
        squash = 1'b0;
        drive(1'b1, 2'd0, 32'd6, 32'd7, 6'd56, 5'd6);
        cycle();
        start = cyc;
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        for (int k = 0; k < 15; k++) cycle();
`ifdef FU_MULT_SQUASH_EN
        n_exp = 1;
`else
        n_exp = 5;
`endif
        chk("squash_retire_count", 64'(retire_cyc.size()), 64'(n_exp));
        if (retire_cyc.size() != 0) begin
            chk("squash_last_value", {32'd0, retire_val[retire_cyc.size()-1]}, 64'd42);
            chk("squash_last_cycle", 64'(retire_cyc[retire_cyc.size()-1]), 64'(start + STAGES));
        end

        // Asynchronous reset mid-operation with 2 entries in flight
        bs_hazard = 1'b1;
        drive(1'b1, 2'd0, 32'd9, 32'd9, 6'd60, 5'd1);
        cycle();
        drive(1'b1, 2'd0, 32'd8, 32'd8, 6'd61, 5'd2);
        cycle();
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        for (int k = 0; k < 4; k++) cycle();
        chk("pre_rst_complete", {63'd0, fum_complete_req}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_complete", {63'd0, fum_complete_req}, 64'd0);
        chk("async_rst_ready", {63'd0, rsb_fu_ready}, 64'd0);
        chk("async_rst_out", {21'd0, out_value, out_prs, out_rob}, 64'd0);
        q.delete();
        cycle();
        rst = 1'b0;
        bs_hazard = 1'b0;
        retire_cyc.delete();
        cycle();
        for (int k = 0; k < 10; k++) cycle();
        chk("post_rst_no_retire", 64'(retire_cyc.size()), 64'd0);

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                  6'($urandom), 5'($urandom));
            bs_hazard = ($urandom_range(0, 9) < 3);
            squash    = ($urandom_range(0, 39) == 0);
            cycle();
        end
        drive(1'b0, 2'd0, '0, '0, '0, '0);
        bs_hazard = 1'b0;
        squash    = 1'b0;
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
